// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM states, default sample
// width and error-counter width.
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int BITSIZE_DEF = 24;
  localparam int ERRCNT_W    = 8;

endpackage

// File: rtl/i2s_slot_shifter.sv
// Per-slot serial-to-parallel shifter: counts captured bits and presents the
// complete word combinationally on the cycle that samples the LSB.
module i2s_slot_shifter
  import i2s_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF
) (
  input  logic               sclk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               capture,
  input  logic               sdata,
  output logic [BITSIZE-1:0] word,
  output logic               done
);

  localparam int CNT_W = $clog2(BITSIZE + 1);

  logic [BITSIZE-2:0] shift_reg;
  logic [CNT_W-1:0]   bit_cnt;

  // clear wins over capture so a boundary LSB still reports done from the old count
  always_ff @(posedge sclk) begin
    if (!resetn || clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (capture) begin
      shift_reg <= {shift_reg[BITSIZE-3:0], sdata};
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  assign word = {shift_reg, sdata};
  assign done = capture && (bit_cnt == CNT_W'(BITSIZE - 1));

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver top: lrclk edge detection, slot FSM, channel registers and valid
// strobe. Define I2S_RX_ERRCNT_EN to build the saturating short-slot counter.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF
) (
  input  logic                sclk,
  input  logic                resetn,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [BITSIZE-1:0]  left_chan,
  output logic [BITSIZE-1:0]  right_chan,
  output logic                valid,
  output logic [ERRCNT_W-1:0] frame_err
);

  state_t             state, state_nxt;
  logic               lr_q;
  logic               lr_edge, fall_edge;
  logic               slot_right;
  logic               left_ok;
  logic               clear, capture, load, short_slot;
  logic [BITSIZE-1:0] word;
  logic               done;

  always_ff @(posedge sclk) lr_q <= lrclk;

  assign lr_edge   = lrclk ^ lr_q;
  assign fall_edge = lr_q & ~lrclk;

  i2s_slot_shifter #(.BITSIZE(BITSIZE)) u_shifter (
    .sclk    (sclk),
    .resetn  (resetn),
    .clear   (clear),
    .capture (capture),
    .sdata   (sdata),
    .word    (word),
    .done    (done)
  );

  always_comb begin
    state_nxt  = state;
    clear      = 1'b0;
    capture    = 1'b0;
    load       = 1'b0;
    short_slot = 1'b0;
    case (state)
      SYNC: begin
        if (fall_edge) begin
          clear     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        capture = 1'b1;
        load    = done;
        // an edge here either lands on the LSB (clean boundary) or cuts the slot short
        if (lr_edge) begin
          clear      = 1'b1;
          short_slot = !done;
        end else if (done) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (lr_edge) begin
          clear     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!resetn) begin
      state      <= SYNC;
      slot_right <= 1'b0;
      left_ok    <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
      valid      <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      if (clear) slot_right <= lrclk;
      // slot_right still names the finishing slot when a load coincides with a new edge
      if (load) begin
        if (slot_right) begin
          right_chan <= word;
          valid      <= left_ok;
          left_ok    <= 1'b0;
        end else begin
          left_chan <= word;
          left_ok   <= 1'b1;
        end
      end
      if (short_slot) left_ok <= 1'b0;
    end
  end

`ifdef I2S_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;

  always_ff @(posedge sclk) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (short_slot && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  assign frame_err = err_cnt;
`else
  assign frame_err = '0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx (BITSIZE=24): full and boundary slots, resets, short
// slots and error saturation; expected frame_err follows I2S_RX_ERRCNT_EN.
module tb_i2s_rx;

  logic        sclk;
  logic        resetn;
  logic        lrclk;
  logic        sdata;
  logic [23:0] left_chan;
  logic [23:0] right_chan;
  logic        valid;
  logic [7:0]  frame_err;

  int          vectors;
  int          miscompares;
  int          valid_cnt;
  logic [23:0] prev_data;
  int          prev_len;

`ifdef I2S_RX_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  i2s_rx #(.BITSIZE(24)) dut (
    .sclk       (sclk),
    .resetn     (resetn),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // valid pulses are tallied away from the active edge; a stuck strobe counts twice
  always @(negedge sclk) begin
    if (valid) valid_cnt = valid_cnt + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] errExp(input int n);
    return ERR_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One slot of len bclk cycles; cycle 0 is the edge and carries the previous slot's bit
  task automatic applyStimulus(input logic lr, input logic [23:0] data, input int len);
    logic tail;
    tail = (prev_len >= 1 && prev_len <= 24) ? prev_data[24-prev_len] : 1'b0;
    for (int k = 0; k < len; k++) begin
      @(negedge sclk);
      lrclk = lr;
      if (k == 0)       sdata = tail;
      else if (k <= 24) sdata = data[24-k];
      else              sdata = 1'b0;
    end
    prev_data = data;
    prev_len  = len;
  endtask

  task automatic doReset(input logic lr, input int cycles);
    @(negedge sclk);
    lrclk  = lr;
    sdata  = 1'b0;
    resetn = 1'b0;
    repeat (cycles) @(negedge sclk);
    resetn    = 1'b1;
    prev_len  = 0;
    prev_data = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    valid_cnt   = 0;
    prev_data   = '0;
    prev_len    = 0;
    resetn      = 1'b0;
    lrclk       = 1'b0;
    sdata       = 1'b0;

    doReset(1'b0, 3);
    checkOutput("reset_left",  32'(left_chan),  32'h0);
    checkOutput("reset_right", 32'(right_chan), 32'h0);
    checkOutput("reset_valid", 32'(valid),      32'h0);
    checkOutput("reset_err",   32'(frame_err),  32'h0);

    // 32-bclk slots
    applyStimulus(1'b1, 24'h000000, 32);
    applyStimulus(1'b0, 24'h123456, 32);
    checkOutput("s32_mid_left",  32'(left_chan),  32'h123456);
    checkOutput("s32_mid_right", 32'(right_chan), 32'h0);
    checkOutput("s32_mid_valid", 32'(valid_cnt),  32'd0);
    applyStimulus(1'b1, 24'hABCDEF, 32);
    for (int f = 0; f < 2; f++) begin
      applyStimulus(1'b0, 24'h123456, 32);
      applyStimulus(1'b1, 24'hABCDEF, 32);
    end
    checkOutput("s32_left",  32'(left_chan),  32'h123456);
    checkOutput("s32_right", 32'(right_chan), 32'hABCDEF);
    checkOutput("s32_valid", 32'(valid_cnt),  32'd3);
    checkOutput("s32_err",   32'(frame_err),  32'h0);

    // 24-bclk slots: LSB capture coincides with the next edge
    doReset(1'b0, 2);
    valid_cnt = 0;
    applyStimulus(1'b1, 24'h000000, 32);
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b0, 24'h800000, 24);
      applyStimulus(1'b1, 24'h7FFFFF, 24);
    end
    applyStimulus(1'b0, 24'h000000, 4);
    checkOutput("s24_left",  32'(left_chan),  32'h800000);
    checkOutput("s24_right", 32'(right_chan), 32'h7FFFFF);
    checkOutput("s24_valid", 32'(valid_cnt),  32'd3);
    checkOutput("s24_err",   32'(frame_err),  32'h0);

    // reset released inside a right slot
    doReset(1'b1, 2);
    valid_cnt = 0;
    applyStimulus(1'b1, 24'hFFFFFF, 32);
    checkOutput("rrel_right0", 32'(right_chan), 32'h0);
    checkOutput("rrel_valid0", 32'(valid_cnt),  32'd0);
    applyStimulus(1'b0, 24'h654321, 32);
    checkOutput("rrel_left1",  32'(left_chan),  32'h654321);
    checkOutput("rrel_right1", 32'(right_chan), 32'h0);
    checkOutput("rrel_valid1", 32'(valid_cnt),  32'd0);
    applyStimulus(1'b1, 24'hFFFFFF, 32);
    checkOutput("rrel_right2", 32'(right_chan), 32'hFFFFFF);
    checkOutput("rrel_valid2", 32'(valid_cnt),  32'd1);

    // left slot truncated after 10 bclk
    doReset(1'b0, 2);
    valid_cnt = 0;
    applyStimulus(1'b1, 24'h000000, 32);
    applyStimulus(1'b0, 24'h111111, 32);
    applyStimulus(1'b1, 24'h222222, 32);
    checkOutput("short_pre_valid", 32'(valid_cnt), 32'd1);
    applyStimulus(1'b0, 24'hAAAAAA, 10);
    applyStimulus(1'b1, 24'h333333, 32);
    checkOutput("short_err",   32'(frame_err),  errExp(1));
    checkOutput("short_left",  32'(left_chan),  32'h111111);
    checkOutput("short_right", 32'(right_chan), 32'h333333);
    checkOutput("short_valid", 32'(valid_cnt),  32'd1);
    applyStimulus(1'b0, 24'h444444, 32);
    applyStimulus(1'b1, 24'h555555, 32);
    checkOutput("short_next_left",  32'(left_chan),  32'h444444);
    checkOutput("short_next_right", 32'(right_chan), 32'h555555);
    checkOutput("short_next_valid", 32'(valid_cnt),  32'd2);

    // 300 consecutive 5-bclk slots
    doReset(1'b0, 2);
    valid_cnt = 0;
    applyStimulus(1'b1, 24'h000000, 32);
    for (int s = 0; s < 11; s++) applyStimulus(1'(s % 2), 24'hF0F0F0, 5);
    checkOutput("sat_err10", 32'(frame_err), errExp(10));
    for (int s = 11; s < 300; s++) applyStimulus(1'(s % 2), 24'hF0F0F0, 5);
    checkOutput("sat_err",   32'(frame_err),  errExp(255));
    checkOutput("sat_valid", 32'(valid_cnt),  32'd0);
    checkOutput("sat_left",  32'(left_chan),  32'h0);
    checkOutput("sat_right", 32'(right_chan), 32'h0);

    // saturated counter holds, then reset pulse mid-left-slot
    valid_cnt = 0;
    applyStimulus(1'b0, 24'h13579B, 32);
    applyStimulus(1'b1, 24'h2468AC, 32);
    checkOutput("hold_err",   32'(frame_err),  errExp(255));
    checkOutput("hold_left",  32'(left_chan),  32'h13579B);
    checkOutput("hold_right", 32'(right_chan), 32'h2468AC);
    checkOutput("hold_valid", 32'(valid_cnt),  32'd1);
    applyStimulus(1'b0, 24'hFEDCBA, 12);
    doReset(1'b0, 1);
    checkOutput("pulse_left",  32'(left_chan),  32'h0);
    checkOutput("pulse_right", 32'(right_chan), 32'h0);
    checkOutput("pulse_valid", 32'(valid),      32'h0);
    checkOutput("pulse_err",   32'(frame_err),  32'h0);
    valid_cnt = 0;
    applyStimulus(1'b0, 24'h000000, 20);
    applyStimulus(1'b1, 24'h999999, 32);
    checkOutput("pulse_sync_right", 32'(right_chan), 32'h0);
    checkOutput("pulse_sync_valid", 32'(valid_cnt),  32'd0);
    applyStimulus(1'b0, 24'h0F0F0F, 32);
    applyStimulus(1'b1, 24'h707070, 32);
    checkOutput("pulse_resume_left",  32'(left_chan),  32'h0F0F0F);
    checkOutput("pulse_resume_right", 32'(right_chan), 32'h707070);
    checkOutput("pulse_resume_valid", 32'(valid_cnt),  32'd1);
    checkOutput("pulse_resume_err",   32'(frame_err),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
